bp_be_store_buffer: RTL and testbench
=====================================

Name: bp_be_store_buffer

Overview:
- Parametrised post-translation store buffer between the memory pipe and the D$ write port.
- Holds stores speculatively until commit and discards uncommitted stores on flush.
- Drains committed stores to the D$ in order and forwards buffered bytes to younger loads, one cycle after the load lookup.
- Adds misaligned-store detection, which the current memory pipe leaves as a TODO.

Parameters:
- els_p, 4: number of entries; power of 2, ≥2.
- paddr_width_p, 40: physical address width.
- dword_width_p, 64: entry data width; byte mask width is dword_width_p/8.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- reset_n_i  in  1  asynchronous, active-low reset.
- st_v_i  in  1  store allocate request.
- st_ready_o  out  1  buffer not full; allocation accepted when st_v_i & st_ready_o & ~st_misaligned_o & ~flush_i.
- st_paddr_i  in  paddr_width_p  store byte address.
- st_size_i  in  2  0=byte, 1=half, 2=word, 3=dword.
- st_data_i  in  dword_width_p  store data, low-justified.
- st_misaligned_o  out  1  combinational: st_v_i & (st_paddr_i mod 2^size ≠ 0).
- commit_v_i  in  1  promote the oldest uncommitted entry to committed.
- flush_i  in  1  discard all uncommitted entries.
- ld_v_i  in  1  load lookup request.
- ld_paddr_i  in  paddr_width_p  load address.
- ld_size_i  in  2  load size.
- ld_fwd_v_o  out  1  registered: a lookup occurred last cycle.
- ld_fwd_hit_o  out  1  all requested bytes supplied by the buffer.
- ld_fwd_partial_o  out  1  some but not all requested bytes overlap; load must replay.
- ld_fwd_data_o  out  dword_width_p  merged bytes, dword-lane aligned.
- drain_v_o  out  1  oldest entry is valid and committed.
- drain_paddr_o  out  paddr_width_p  dword-aligned address.
- drain_mask_o  out  dword_width_p/8  byte mask.
- drain_data_o  out  dword_width_p  lane-aligned data.
- drain_yumi_i  in  1  D$ consumes the drain entry; legal only while drain_v_o.
- empty_o  out  1  no valid entries.
- full_o  out  1  els_p valid entries.

Behaviour:
- **Pointers.** Circular buffer with head (oldest), cmt (first uncommitted) and tail, each $clog2(els_p)+1 bits including a wrap bit.
  - full = index equal, wrap differs; empty = head==tail.
- **Reset.** All pointers 0. Outputs: ld_fwd_* = 0, drain_v_o = 0, empty_o = 1, full_o = 0, st_ready_o = 1.
- **Allocate.** Entry = {paddr & ~7, mask = ((1<<2^size)-1) << paddr[2:0], data = st_data_i << 8*paddr[2:0]}; tail++.
  - st_ready_o = ~full_o. It does not account for a same-cycle drain.
  - A misaligned store is never allocated.
- **Commit.** cmt++ only if cmt≠tail; otherwise commit_v_i is ignored.
- **Flush.** tail ← cmt after the same-cycle commit is applied. flush_i beats st_v_i: the store is dropped.
- **Drain.** drain_v_o = (head≠cmt). On drain_yumi_i: head++. Drain, commit and allocate may all occur in one cycle.
- **Forwarding.**
  - Match = valid entry with equal dword address.
  - Per byte lane of the load mask, the youngest matching entry supplies the byte. Scan is tail-1 down to head and covers committed and uncommitted entries.
  - Inputs are registered next cycle: hit = covered == ldmask; partial = covered≠0 & covered≠ldmask.
  - Uncovered lanes of ld_fwd_data_o are 0.
  - A flush in the lookup cycle does not cancel the response.
- **Mid-operation reset.** Async assertion clears all state immediately. Deassertion is synchronised externally.

Decomposition:
- bp_be_pkg gets:
  - bp_be_sbuf_size_e (byte/half/word/dword).
  - `declare_bp_be_sbuf_entry_s(paddr_width_p, dword_width_p)` macro {paddr, mask, data}.
  - `bp_be_sbuf_entry_width` macro.
- One sub-module: bp_be_sbuf_fwd_merge, a combinational youngest-wins byte merge over the entry array given head/tail.
- Entry storage is flops inside bp_be_store_buffer. No RAM.

Test Plan:
- **Allocate/commit/drain.** sw 0xDEADBEEF @0x1004, commit, yumi → drain_paddr=0x1000, mask=0xF0, data=0xDEADBEEF_00000000; then empty_o=1.
- **Full and same-cycle drain.** Fill 4 committed stores → full_o=1, st_ready_o=0. A store offered during the drain cycle is rejected. The next store is accepted; 4 drains follow in allocation order.
- **Flush with commit.** 3 stores, commit 1, then flush_i & commit_v_i in one cycle → 2 entries remain; drain yields stores 0 and 1 only. A st_v_i in the flush cycle is not allocated.
- **Forwarding, youngest wins.**
  - sd 0x1111111111111111 @0x2000, then sb 0xAA @0x2003.
  - ld dword @0x2000 → next cycle hit=1, data=0x11111111AA111111.
  - lw @0x2004 with only the sb buffered → partial=0, hit=0.
- **Partial overlap and misalignment.**
  - sh @0x3002, then lw @0x3000 → partial=1, hit=0.
  - sw @0x3002 → st_misaligned_o=1, count unchanged.
- **Async reset mid-drain.** Assert reset_n_i=0 with drain_v_o=1 between clock edges → drain_v_o=0 and empty_o=1 before the next edge.

Source files
------------

// File: rtl/bp_be_pkg.sv
// ---------------------------------------------------------------------------
// bp_be_pkg
// Shared types for the back-end store buffer.
//   bp_be_sbuf_size_e            : access size encoding (byte/half/word/dword)
//   sbuf_size_bytes()            : number of bytes touched by an access size
//   `DECLARE_BP_BE_SBUF_ENTRY_S  : entry struct {paddr, mask, data}
//   `BP_BE_SBUF_ENTRY_WIDTH      : packed width of that entry struct
// ---------------------------------------------------------------------------
`ifndef BP_BE_PKG_SV
`define BP_BE_PKG_SV

`define DECLARE_BP_BE_SBUF_ENTRY_S(paddr_width_mp, dword_width_mp) \
  typedef struct packed { \
    logic [(paddr_width_mp)-1:0]     paddr; \
    logic [((dword_width_mp)/8)-1:0] mask; \
    logic [(dword_width_mp)-1:0]     data; \
  } bp_be_sbuf_entry_s

`define BP_BE_SBUF_ENTRY_WIDTH(paddr_width_mp, dword_width_mp) \
  ((paddr_width_mp) + ((dword_width_mp)/8) + (dword_width_mp))

package bp_be_pkg;

  typedef enum logic [1:0] {
    e_sbuf_byte  = 2'd0,
    e_sbuf_half  = 2'd1,
    e_sbuf_word  = 2'd2,
    e_sbuf_dword = 2'd3
  } bp_be_sbuf_size_e;

  function automatic int unsigned sbuf_size_bytes(input bp_be_sbuf_size_e size);
    return 32'd1 << size;
  endfunction

endpackage

`endif

// File: rtl/bp_be_store_buffer_if.sv
// ---------------------------------------------------------------------------
// bp_be_store_buffer_if
// Bundles every non-clock/reset signal of the store buffer.
//   store  : st_v_i, st_ready_o, st_paddr_i, st_size_i, st_data_i,
//            st_misaligned_o
//   control: commit_v_i, flush_i
//   load   : ld_v_i, ld_paddr_i, ld_size_i, ld_fwd_v_o, ld_fwd_hit_o,
//            ld_fwd_partial_o, ld_fwd_data_o
//   drain  : drain_v_o, drain_paddr_o, drain_mask_o, drain_data_o,
//            drain_yumi_i
//   status : empty_o, full_o
// Suffixes are from the buffer's point of view. slave = the buffer,
// master = the memory pipe / D$ side.
// ---------------------------------------------------------------------------
interface bp_be_store_buffer_if #(
  parameter int paddr_width_p = 40,
  parameter int dword_width_p = 64
);
  logic                         st_v_i;
  logic                         st_ready_o;
  logic [paddr_width_p-1:0]     st_paddr_i;
  logic [1:0]                   st_size_i;
  logic [dword_width_p-1:0]     st_data_i;
  logic                         st_misaligned_o;

  logic                         commit_v_i;
  logic                         flush_i;

  logic                         ld_v_i;
  logic [paddr_width_p-1:0]     ld_paddr_i;
  logic [1:0]                   ld_size_i;
  logic                         ld_fwd_v_o;
  logic                         ld_fwd_hit_o;
  logic                         ld_fwd_partial_o;
  logic [dword_width_p-1:0]     ld_fwd_data_o;

  logic                         drain_v_o;
  logic [paddr_width_p-1:0]     drain_paddr_o;
  logic [dword_width_p/8-1:0]   drain_mask_o;
  logic [dword_width_p-1:0]     drain_data_o;
  logic                         drain_yumi_i;

  logic                         empty_o;
  logic                         full_o;

  modport slave (
    input  st_v_i, st_paddr_i, st_size_i, st_data_i,
    output st_ready_o, st_misaligned_o,
    input  commit_v_i, flush_i,
    input  ld_v_i, ld_paddr_i, ld_size_i,
    output ld_fwd_v_o, ld_fwd_hit_o, ld_fwd_partial_o, ld_fwd_data_o,
    output drain_v_o, drain_paddr_o, drain_mask_o, drain_data_o,
    input  drain_yumi_i,
    output empty_o, full_o
  );

  modport master (
    output st_v_i, st_paddr_i, st_size_i, st_data_i,
    input  st_ready_o, st_misaligned_o,
    output commit_v_i, flush_i,
    output ld_v_i, ld_paddr_i, ld_size_i,
    input  ld_fwd_v_o, ld_fwd_hit_o, ld_fwd_partial_o, ld_fwd_data_o,
    input  drain_v_o, drain_paddr_o, drain_mask_o, drain_data_o,
    output drain_yumi_i,
    input  empty_o, full_o
  );
endinterface

// File: rtl/bp_be_sbuf_fwd_merge.sv
// ---------------------------------------------------------------------------
// bp_be_sbuf_fwd_merge
// Combinational youngest-wins byte merge over the store buffer entries.
//   entries_i  : all entry slots, packed {paddr, mask, data}
//   head_i     : pointer to the oldest valid entry (with wrap bit)
//   tail_i     : pointer one past the youngest valid entry (with wrap bit)
//   ld_daddr_i : dword-aligned load address
//   ld_mask_i  : byte lanes requested by the load
//   covered_o  : requested lanes supplied by some matching entry
//   data_o     : merged bytes, uncovered lanes are zero
// ---------------------------------------------------------------------------
module bp_be_sbuf_fwd_merge
  import bp_be_pkg::*;
#(
  parameter int els_p         = 4,
  parameter int paddr_width_p = 40,
  parameter int dword_width_p = 64,
  localparam int mask_w_lp    = dword_width_p / 8,
  localparam int idx_w_lp     = $clog2(els_p),
  localparam int ptr_w_lp     = idx_w_lp + 1,
  localparam int entry_w_lp   = `BP_BE_SBUF_ENTRY_WIDTH(paddr_width_p, dword_width_p)
) (
  input  logic [els_p-1:0][entry_w_lp-1:0] entries_i,
  input  logic [ptr_w_lp-1:0]              head_i,
  input  logic [ptr_w_lp-1:0]              tail_i,
  input  logic [paddr_width_p-1:0]         ld_daddr_i,
  input  logic [mask_w_lp-1:0]             ld_mask_i,
  output logic [mask_w_lp-1:0]             covered_o,
  output logic [dword_width_p-1:0]         data_o
);

  `DECLARE_BP_BE_SBUF_ENTRY_S(paddr_width_p, dword_width_p);

  bp_be_sbuf_entry_s     entry [els_p];
  logic [els_p-1:0]      match;
  logic [ptr_w_lp-1:0]   count;
  logic [idx_w_lp-1:0]   slot;

  // Occupancy; the wrap bit makes a full buffer count as els_p, not 0.
  assign count = tail_i - head_i;

  genvar gi;
  generate
    for (gi = 0; gi < els_p; gi++) begin : g_slot
      logic [idx_w_lp-1:0] age;
      assign entry[gi] = entries_i[gi];
      // Age is the slot's distance from head; only the first `count` slots hold live data.
      assign age       = idx_w_lp'(gi) - head_i[idx_w_lp-1:0];
      assign match[gi] = ({1'b0, age} < count) && (entry[gi].paddr == ld_daddr_i);
    end
  endgenerate

  // Walk oldest to youngest so a younger writer overwrites an older one per lane.
  always_comb begin
    covered_o = '0;
    data_o    = '0;
    slot      = '0;
    for (int k = 0; k < els_p; k++) begin
      slot = head_i[idx_w_lp-1:0] + idx_w_lp'(k);
      if (match[slot]) begin
        for (int b = 0; b < mask_w_lp; b++) begin
          if (entry[slot].mask[b] && ld_mask_i[b]) begin
            covered_o[b]      = 1'b1;
            data_o[8*b +: 8]  = entry[slot].data[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/bp_be_store_buffer.sv
// ---------------------------------------------------------------------------
// bp_be_store_buffer
// Post-translation store buffer between the memory pipe and the D$ write
// port. Stores are held speculatively until commit, uncommitted stores are
// discarded on flush, committed stores drain to the D$ in order, and younger
// loads get buffered bytes forwarded one cycle after their lookup.
//   clk_i     : clock, all state updates on posedge
//   reset_n_i : asynchronous active-low reset
//   sb_if     : store / commit / flush / load / drain / status signals
// ---------------------------------------------------------------------------
module bp_be_store_buffer
  import bp_be_pkg::*;
#(
  parameter int els_p         = 4,
  parameter int paddr_width_p = 40,
  parameter int dword_width_p = 64
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  bp_be_store_buffer_if.slave  sb_if
);

  localparam int mask_w_lp  = dword_width_p / 8;
  localparam int off_w_lp   = $clog2(mask_w_lp);
  localparam int idx_w_lp   = $clog2(els_p);
  localparam int ptr_w_lp   = idx_w_lp + 1;
  localparam int entry_w_lp = `BP_BE_SBUF_ENTRY_WIDTH(paddr_width_p, dword_width_p);

  `DECLARE_BP_BE_SBUF_ENTRY_S(paddr_width_p, dword_width_p);

  // Byte lanes touched by an access of `size` starting at lane `off`.
  function automatic logic [mask_w_lp-1:0] lane_mask(input logic [1:0] size,
                                                     input logic [off_w_lp-1:0] off);
    logic [31:0] base;
    base = (32'd1 << sbuf_size_bytes(bp_be_sbuf_size_e'(size))) - 32'd1;
    return mask_w_lp'(base) << off;
  endfunction

  bp_be_sbuf_entry_s                entries_q [els_p];
  bp_be_sbuf_entry_s                entries_d [els_p];
  logic [ptr_w_lp-1:0]              head_q, head_d;
  logic [ptr_w_lp-1:0]              cmt_q, cmt_d;
  logic [ptr_w_lp-1:0]              tail_q, tail_d;
  logic                             fwd_v_q, fwd_v_d;
  logic                             fwd_hit_q, fwd_hit_d;
  logic                             fwd_partial_q, fwd_partial_d;
  logic [dword_width_p-1:0]         fwd_data_q, fwd_data_d;

  logic                             full, empty;
  logic                             misaligned;
  logic                             alloc, commit, drain;
  bp_be_sbuf_entry_s                new_entry;
  logic [off_w_lp-1:0]              st_off;
  logic [off_w_lp-1:0]              align_chk;
  logic [mask_w_lp-1:0]             ld_mask;
  logic [paddr_width_p-1:0]         ld_daddr;
  logic [mask_w_lp-1:0]             covered;
  logic [dword_width_p-1:0]         merge_data;
  logic [els_p-1:0][entry_w_lp-1:0] entries_flat;

  // ---------------- status ----------------
  assign empty = (head_q == tail_q);
  assign full  = (head_q[idx_w_lp-1:0] == tail_q[idx_w_lp-1:0]) &&
                 (head_q[idx_w_lp] != tail_q[idx_w_lp]);

  // ---------------- store side ----------------
  assign st_off     = sb_if.st_paddr_i[off_w_lp-1:0];
  assign align_chk  = off_w_lp'(sbuf_size_bytes(bp_be_sbuf_size_e'(sb_if.st_size_i)) - 32'd1);
  assign misaligned = sb_if.st_v_i && |(st_off & align_chk);

  // Ready deliberately ignores a same-cycle drain to keep it off the D$ path.
  assign alloc  = sb_if.st_v_i && !full && !misaligned && !sb_if.flush_i;
  assign commit = sb_if.commit_v_i && (cmt_q != tail_q);
  assign drain  = (head_q != cmt_q) && sb_if.drain_yumi_i;

  assign new_entry.paddr = {sb_if.st_paddr_i[paddr_width_p-1:off_w_lp], off_w_lp'(0)};
  assign new_entry.mask  = lane_mask(sb_if.st_size_i, st_off);
  assign new_entry.data  = sb_if.st_data_i << {st_off, 3'b000};

  // ---------------- pointer / entry next state ----------------
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q + ptr_w_lp'(drain);
    cmt_d     = cmt_q + ptr_w_lp'(commit);
    tail_d    = tail_q + ptr_w_lp'(alloc);
    if (alloc) begin
      entries_d[tail_q[idx_w_lp-1:0]] = new_entry;
    end
    // Flush trims back to the commit point after this cycle's commit is applied.
    if (sb_if.flush_i) begin
      tail_d = cmt_d;
    end
  end

  // ---------------- load forwarding ----------------
  assign ld_mask  = lane_mask(sb_if.ld_size_i, sb_if.ld_paddr_i[off_w_lp-1:0]);
  assign ld_daddr = {sb_if.ld_paddr_i[paddr_width_p-1:off_w_lp], off_w_lp'(0)};

  genvar gi;
  generate
    for (gi = 0; gi < els_p; gi++) begin : g_flat
      assign entries_flat[gi] = entries_q[gi];
    end
  endgenerate

  bp_be_sbuf_fwd_merge #(
    .els_p         (els_p),
    .paddr_width_p (paddr_width_p),
    .dword_width_p (dword_width_p)
  ) u_fwd_merge (
    .entries_i  (entries_flat),
    .head_i     (head_q),
    .tail_i     (tail_q),
    .ld_daddr_i (ld_daddr),
    .ld_mask_i  (ld_mask),
    .covered_o  (covered),
    .data_o     (merge_data)
  );

  // The lookup sees the buffer as it stood before this cycle's updates; a
  // flush in the same cycle does not suppress the response.
  always_comb begin
    fwd_v_d       = sb_if.ld_v_i;
    fwd_hit_d     = sb_if.ld_v_i && (covered == ld_mask);
    fwd_partial_d = sb_if.ld_v_i && (covered != '0) && (covered != ld_mask);
    fwd_data_d    = sb_if.ld_v_i ? merge_data : '0;
  end

  // ---------------- state ----------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_q        <= '0;
      cmt_q         <= '0;
      tail_q        <= '0;
      fwd_v_q       <= 1'b0;
      fwd_hit_q     <= 1'b0;
      fwd_partial_q <= 1'b0;
      fwd_data_q    <= '0;
      for (int i = 0; i < els_p; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q        <= head_d;
      cmt_q         <= cmt_d;
      tail_q        <= tail_d;
      fwd_v_q       <= fwd_v_d;
      fwd_hit_q     <= fwd_hit_d;
      fwd_partial_q <= fwd_partial_d;
      fwd_data_q    <= fwd_data_d;
      for (int i = 0; i < els_p; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

  // ---------------- outputs ----------------
  assign sb_if.st_ready_o       = !full;
  assign sb_if.st_misaligned_o  = misaligned;
  assign sb_if.empty_o          = empty;
  assign sb_if.full_o           = full;

  assign sb_if.drain_v_o        = (head_q != cmt_q);
  assign sb_if.drain_paddr_o    = entries_q[head_q[idx_w_lp-1:0]].paddr;
  assign sb_if.drain_mask_o     = entries_q[head_q[idx_w_lp-1:0]].mask;
  assign sb_if.drain_data_o     = entries_q[head_q[idx_w_lp-1:0]].data;

  assign sb_if.ld_fwd_v_o       = fwd_v_q;
  assign sb_if.ld_fwd_hit_o     = fwd_hit_q;
  assign sb_if.ld_fwd_partial_o = fwd_partial_q;
  assign sb_if.ld_fwd_data_o    = fwd_data_q;

endmodule

// File: tb/tb_bp_be_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_bp_be_store_buffer
// Directed scenarios for bp_be_store_buffer with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_bp_be_store_buffer;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bp_be_store_buffer_if #(.paddr_width_p(40), .dword_width_p(64)) sb_if ();

  bp_be_store_buffer #(
    .els_p         (4),
    .paddr_width_p (40),
    .dword_width_p (64)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .sb_if     (sb_if.slave)
  );

  task automatic clr_inputs();
    sb_if.st_v_i       = 1'b0;
    sb_if.st_paddr_i   = '0;
    sb_if.st_size_i    = 2'd0;
    sb_if.st_data_i    = '0;
    sb_if.commit_v_i   = 1'b0;
    sb_if.flush_i      = 1'b0;
    sb_if.ld_v_i       = 1'b0;
    sb_if.ld_paddr_i   = '0;
    sb_if.ld_size_i    = 2'd0;
    sb_if.drain_yumi_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic store(input logic [39:0] a, input logic [1:0] s, input logic [63:0] d);
    sb_if.st_v_i     = 1'b1;
    sb_if.st_paddr_i = a;
    sb_if.st_size_i  = s;
    sb_if.st_data_i  = d;
    tick();
    sb_if.st_v_i     = 1'b0;
  endtask

  task automatic commit1();
    sb_if.commit_v_i = 1'b1;
    tick();
    sb_if.commit_v_i = 1'b0;
  endtask

  task automatic drain1();
    sb_if.drain_yumi_i = 1'b1;
    tick();
    sb_if.drain_yumi_i = 1'b0;
  endtask

  task automatic load(input logic [39:0] a, input logic [1:0] s);
    sb_if.ld_v_i     = 1'b1;
    sb_if.ld_paddr_i = a;
    sb_if.ld_size_i  = s;
    tick();
    sb_if.ld_v_i     = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clr_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++; if (sb_if.empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %0h exp 1", sb_if.empty_o); end
    checks++; if (sb_if.full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %0h exp 0", sb_if.full_o); end
    checks++; if (sb_if.st_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h exp 1", sb_if.st_ready_o); end
    checks++; if (sb_if.drain_v_o !== 1'b0) begin errors++; $display("FAIL reset_drain_v got %0h exp 0", sb_if.drain_v_o); end
    checks++; if (sb_if.ld_fwd_v_o !== 1'b0) begin errors++; $display("FAIL reset_fwd_v got %0h exp 0", sb_if.ld_fwd_v_o); end
    checks++; if ({sb_if.ld_fwd_hit_o, sb_if.ld_fwd_partial_o} !== 2'b00) begin errors++; $display("FAIL reset_fwd_hp got %0b exp 00", {sb_if.ld_fwd_hit_o, sb_if.ld_fwd_partial_o}); end
    $display("reset: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_alloc_drain();
    store(40'h1004, 2'd2, 64'hDEADBEEF);
    checks++; if (sb_if.empty_o !== 1'b0) begin errors++; $display("FAIL ad_empty_after_st got %0h exp 0", sb_if.empty_o); end
    checks++; if (sb_if.drain_v_o !== 1'b0) begin errors++; $display("FAIL ad_drain_v_uncommitted got %0h exp 0", sb_if.drain_v_o); end
    commit1();
    checks++; if (sb_if.drain_v_o !== 1'b1) begin errors++; $display("FAIL ad_drain_v got %0h exp 1", sb_if.drain_v_o); end
    checks++; if (sb_if.drain_paddr_o !== 40'h1000) begin errors++; $display("FAIL ad_paddr got %0h exp 1000", sb_if.drain_paddr_o); end
    checks++; if (sb_if.drain_mask_o !== 8'hF0) begin errors++; $display("FAIL ad_mask got %0h exp f0", sb_if.drain_mask_o); end
    checks++; if (sb_if.drain_data_o !== 64'hDEADBEEF_00000000) begin errors++; $display("FAIL ad_data got %0h exp deadbeef00000000", sb_if.drain_data_o); end
    drain1();
    checks++; if (sb_if.empty_o !== 1'b1) begin errors++; $display("FAIL ad_empty_after_drain got %0h exp 1", sb_if.empty_o); end
    checks++; if (sb_if.drain_v_o !== 1'b0) begin errors++; $display("FAIL ad_drain_v_after got %0h exp 0", sb_if.drain_v_o); end
    $display("alloc_drain: sw 0xdeadbeef @0x1004 drained, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_full();
    logic [39:0] exp_addr [4];
    logic [63:0] exp_data [4];
    for (int i = 0; i < 4; i++) store(40'h4000 + 40'(8 * i), 2'd3, 64'hA0 + 64'(i));
    checks++; if (sb_if.full_o !== 1'b1) begin errors++; $display("FAIL full_full got %0h exp 1", sb_if.full_o); end
    checks++; if (sb_if.st_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %0h exp 0", sb_if.st_ready_o); end
    for (int i = 0; i < 4; i++) commit1();
    // Store offered in the same cycle as the first drain: must be rejected.
    sb_if.st_v_i       = 1'b1;
    sb_if.st_paddr_i   = 40'h5000;
    sb_if.st_size_i    = 2'd3;
    sb_if.st_data_i    = 64'h55;
    sb_if.drain_yumi_i = 1'b1;
    #1;
    checks++; if (sb_if.st_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready_drain_cycle got %0h exp 0", sb_if.st_ready_o); end
    checks++; if (sb_if.drain_paddr_o !== 40'h4000) begin errors++; $display("FAIL full_drain0_paddr got %0h exp 4000", sb_if.drain_paddr_o); end
    tick();
    sb_if.st_v_i       = 1'b0;
    sb_if.drain_yumi_i = 1'b0;
    checks++; if (sb_if.full_o !== 1'b0) begin errors++; $display("FAIL full_after_reject got %0h exp 0", sb_if.full_o); end
    store(40'h5000, 2'd3, 64'h55);
    checks++; if (sb_if.full_o !== 1'b1) begin errors++; $display("FAIL full_after_accept got %0h exp 1", sb_if.full_o); end
    commit1();
    exp_addr = '{40'h4008, 40'h4010, 40'h4018, 40'h5000};
    exp_data = '{64'hA1, 64'hA2, 64'hA3, 64'h55};
    for (int i = 0; i < 4; i++) begin
      checks++; if (sb_if.drain_v_o !== 1'b1) begin errors++; $display("FAIL full_drain_v[%0d] got %0h exp 1", i, sb_if.drain_v_o); end
      checks++; if (sb_if.drain_paddr_o !== exp_addr[i]) begin errors++; $display("FAIL full_drain_paddr[%0d] got %0h exp %0h", i, sb_if.drain_paddr_o, exp_addr[i]); end
      checks++; if (sb_if.drain_data_o !== exp_data[i]) begin errors++; $display("FAIL full_drain_data[%0d] got %0h exp %0h", i, sb_if.drain_data_o, exp_data[i]); end
      drain1();
    end
    checks++; if (sb_if.empty_o !== 1'b1) begin errors++; $display("FAIL full_empty_end got %0h exp 1", sb_if.empty_o); end
    $display("full: 4 fills, rejected drain-cycle store, 4 ordered drains, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_flush_commit();
    store(40'h6000, 2'd3, 64'h60);
    store(40'h6008, 2'd3, 64'h61);
    store(40'h6010, 2'd3, 64'h62);
    commit1();
    sb_if.flush_i    = 1'b1;
    sb_if.commit_v_i = 1'b1;
    sb_if.st_v_i     = 1'b1;
    sb_if.st_paddr_i = 40'h6018;
    sb_if.st_size_i  = 2'd3;
    sb_if.st_data_i  = 64'h63;
    tick();
    clr_inputs();
    // Nothing uncommitted should remain, so this commit must be a no-op.
    commit1();
    checks++; if (sb_if.drain_paddr_o !== 40'h6000) begin errors++; $display("FAIL flush_drain0 got %0h exp 6000", sb_if.drain_paddr_o); end
    drain1();
    checks++; if (sb_if.drain_paddr_o !== 40'h6008) begin errors++; $display("FAIL flush_drain1 got %0h exp 6008", sb_if.drain_paddr_o); end
    checks++; if (sb_if.drain_v_o !== 1'b1) begin errors++; $display("FAIL flush_drain1_v got %0h exp 1", sb_if.drain_v_o); end
    drain1();
    checks++; if (sb_if.drain_v_o !== 1'b0) begin errors++; $display("FAIL flush_drain_v_end got %0h exp 0", sb_if.drain_v_o); end
    checks++; if (sb_if.empty_o !== 1'b1) begin errors++; $display("FAIL flush_empty_end got %0h exp 1", sb_if.empty_o); end
    $display("flush_commit: 2 of 3 stores survive, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_fwd_youngest();
    store(40'h2000, 2'd3, 64'h1111111111111111);
    store(40'h2003, 2'd0, 64'hAA);
    load(40'h2000, 2'd3);
    checks++; if (sb_if.ld_fwd_v_o !== 1'b1) begin errors++; $display("FAIL fwd_v got %0h exp 1", sb_if.ld_fwd_v_o); end
    checks++; if (sb_if.ld_fwd_hit_o !== 1'b1) begin errors++; $display("FAIL fwd_hit got %0h exp 1", sb_if.ld_fwd_hit_o); end
    checks++; if (sb_if.ld_fwd_partial_o !== 1'b0) begin errors++; $display("FAIL fwd_partial got %0h exp 0", sb_if.ld_fwd_partial_o); end
    checks++; if (sb_if.ld_fwd_data_o !== 64'h11111111AA111111) begin errors++; $display("FAIL fwd_data got %0h exp 11111111aa111111", sb_if.ld_fwd_data_o); end
    commit1();
    commit1();
    drain1();
    load(40'h2004, 2'd2);
    checks++; if (sb_if.ld_fwd_v_o !== 1'b1) begin errors++; $display("FAIL fwd_lw_v got %0h exp 1", sb_if.ld_fwd_v_o); end
    checks++; if ({sb_if.ld_fwd_hit_o, sb_if.ld_fwd_partial_o} !== 2'b00) begin errors++; $display("FAIL fwd_lw_hp got %0b exp 00", {sb_if.ld_fwd_hit_o, sb_if.ld_fwd_partial_o}); end
    checks++; if (sb_if.ld_fwd_data_o !== 64'h0) begin errors++; $display("FAIL fwd_lw_data got %0h exp 0", sb_if.ld_fwd_data_o); end
    tick();
    checks++; if (sb_if.ld_fwd_v_o !== 1'b0) begin errors++; $display("FAIL fwd_v_idle got %0h exp 0", sb_if.ld_fwd_v_o); end
    drain1();
    checks++; if (sb_if.empty_o !== 1'b1) begin errors++; $display("FAIL fwd_empty_end got %0h exp 1", sb_if.empty_o); end
    $display("fwd_youngest: sd+sb merge, lw no overlap, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_partial_misalign();
    sb_if.st_v_i     = 1'b1;
    sb_if.st_paddr_i = 40'h3002;
    sb_if.st_size_i  = 2'd1;
    sb_if.st_data_i  = 64'hBEEF;
    #1;
    checks++; if (sb_if.st_misaligned_o !== 1'b0) begin errors++; $display("FAIL pm_sh_misaligned got %0h exp 0", sb_if.st_misaligned_o); end
    tick();
    sb_if.st_v_i = 1'b0;
    load(40'h3000, 2'd2);
    checks++; if (sb_if.ld_fwd_partial_o !== 1'b1) begin errors++; $display("FAIL pm_partial got %0h exp 1", sb_if.ld_fwd_partial_o); end
    checks++; if (sb_if.ld_fwd_hit_o !== 1'b0) begin errors++; $display("FAIL pm_hit got %0h exp 0", sb_if.ld_fwd_hit_o); end
    checks++; if (sb_if.ld_fwd_data_o !== 64'h00000000BEEF0000) begin errors++; $display("FAIL pm_data got %0h exp beef0000", sb_if.ld_fwd_data_o); end
    sb_if.st_v_i     = 1'b1;
    sb_if.st_paddr_i = 40'h3002;
    sb_if.st_size_i  = 2'd2;
    sb_if.st_data_i  = 64'h12345678;
    #1;
    checks++; if (sb_if.st_misaligned_o !== 1'b1) begin errors++; $display("FAIL pm_sw_misaligned got %0h exp 1", sb_if.st_misaligned_o); end
    tick();
    sb_if.st_v_i = 1'b0;
    // If the misaligned store had been allocated, the second commit would promote it.
    commit1();
    commit1();
    drain1();
    checks++; if (sb_if.empty_o !== 1'b1) begin errors++; $display("FAIL pm_count_unchanged got empty=%0h exp 1", sb_if.empty_o); end
    $display("partial_misalign: sh/lw partial, sw@3002 rejected, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_async_reset();
    store(40'h7000, 2'd3, 64'h77);
    commit1();
    checks++; if (sb_if.drain_v_o !== 1'b1) begin errors++; $display("FAIL ar_drain_v_before got %0h exp 1", sb_if.drain_v_o); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (sb_if.drain_v_o !== 1'b0) begin errors++; $display("FAIL ar_drain_v got %0h exp 0", sb_if.drain_v_o); end
    checks++; if (sb_if.empty_o !== 1'b1) begin errors++; $display("FAIL ar_empty got %0h exp 1", sb_if.empty_o); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++; if (sb_if.st_ready_o !== 1'b1) begin errors++; $display("FAIL ar_ready_after got %0h exp 1", sb_if.st_ready_o); end
    checks++; if (sb_if.empty_o !== 1'b1) begin errors++; $display("FAIL ar_empty_after got %0h exp 1", sb_if.empty_o); end
    $display("async_reset: mid-drain reset clears state, checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_alloc_drain();
    test_full();
    test_flush_commit();
    test_fwd_youngest();
    test_partial_misalign();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
